// File: rtl/recv_logic.sv
// ---------------------------------------------------------------------------
// recv_logic
//
// Receives one pixel buffer at a time from a set of first-word-fall-through
// FIFOs. A buffer begins when all four control FIFOs (size, pivot, median
// position, second-median value) hold a word. Those four words are popped
// together and latched. Pixels are then popped one by one and written to a
// local buffer, addressed 0..size-1. When the buffer is complete the block
// raises result_valid and holds its outputs until result_ack is seen.
//
// Optional feature (macro RECV_PIVOT_STATS_EN):
//   When defined, each received pixel is compared (unsigned) against the
//   latched pivot, and the result is tallied in lt_count, eq_count or
//   gt_count. When undefined, all three counts are tied to 0.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   recv_px*                  pixel FIFO: data, empty flag, pop
//   recv_pivot*               pivot FIFO
//   recv_buff_size*           buffer size FIFO (values above BUFF_SIZE are clamped)
//   recv_median_pos*          median position FIFO
//   recv_second_median_value* second-median FIFO
//   buf_wr/buf_addr/buf_data  local pixel buffer write port
//   lt/eq/gt_count            number of pixels below, equal to, above the pivot
//   *_q                       control words latched for the current buffer
//   result_valid, result_ack  completion handshake
//   receiving                 high while pixels are being collected
// ---------------------------------------------------------------------------
module recv_logic #(
   parameter int BUFF_SIZE     = 32,
   parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
   parameter int PX_WIDTH      = 8
) (
   input  logic                     clk,
   input  logic                     rst,

   input  logic [PX_WIDTH-1:0]      recv_px,
   input  logic                     recv_px_empty,
   output logic                     recv_px_rd,

   input  logic [PX_WIDTH-1:0]      recv_pivot,
   input  logic                     recv_pivot_empty,
   output logic                     recv_pivot_rd,

   input  logic [BUFF_SIZE_BIT-1:0] recv_buff_size,
   input  logic                     recv_buff_size_empty,
   output logic                     recv_buff_size_rd,

   input  logic [BUFF_SIZE_BIT-1:0] recv_median_pos,
   input  logic                     recv_median_pos_empty,
   output logic                     recv_median_pos_rd,

   input  logic [PX_WIDTH-1:0]      recv_second_median_value,
   input  logic                     recv_second_median_value_empty,
   output logic                     recv_second_median_value_rd,

   output logic                     buf_wr,
   output logic [BUFF_SIZE_BIT-1:0] buf_addr,
   output logic [PX_WIDTH-1:0]      buf_data,

   output logic [BUFF_SIZE_BIT-1:0] lt_count,
   output logic [BUFF_SIZE_BIT-1:0] eq_count,
   output logic [BUFF_SIZE_BIT-1:0] gt_count,

   output logic [PX_WIDTH-1:0]      pivot_q,
   output logic [BUFF_SIZE_BIT-1:0] buff_size_q,
   output logic [BUFF_SIZE_BIT-1:0] median_pos_q,
   output logic [PX_WIDTH-1:0]      second_median_value_q,

   output logic                     result_valid,
   input  logic                     result_ack,
   output logic                     receiving
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [BUFF_SIZE_BIT-1:0] SIZE_MAX = BUFF_SIZE_BIT'(BUFF_SIZE);
   localparam logic [BUFF_SIZE_BIT-1:0] ONE      = BUFF_SIZE_BIT'(1);

   state_t                   state;
   state_t                   state_next;
   logic [BUFF_SIZE_BIT-1:0] idx;
   logic [BUFF_SIZE_BIT-1:0] idx_next;
   logic [BUFF_SIZE_BIT-1:0] size_clamped;
   logic                     ctrl_ready;
   logic                     ctrl_pop;
   logic                     px_pop;
   logic                     last_px;

   // Oversized requests are truncated so the buffer can never be overrun.
   assign size_clamped = (recv_buff_size > SIZE_MAX) ? SIZE_MAX : recv_buff_size;

   assign ctrl_ready = ~recv_buff_size_empty & ~recv_pivot_empty &
                       ~recv_median_pos_empty & ~recv_second_median_value_empty;

   // Only evaluated in RECV, where buff_size_q is known to be non-zero.
   assign last_px = (idx == (buff_size_q - ONE));

   // ------------------------------------------------------------------
   // State register and per-buffer registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                 <= IDLE;
         idx                   <= '0;
         pivot_q               <= '0;
         buff_size_q           <= '0;
         median_pos_q          <= '0;
         second_median_value_q <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         if (ctrl_pop) begin
            pivot_q               <= recv_pivot;
            buff_size_q           <= size_clamped;
            median_pos_q          <= recv_median_pos;
            second_median_value_q <= recv_second_median_value;
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state and pop decode
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state;
      idx_next   = idx;
      ctrl_pop   = 1'b0;
      px_pop     = 1'b0;

      case (state)
         IDLE: begin
            if (ctrl_ready) begin
               ctrl_pop   = 1'b1;
               idx_next   = '0;
               // An empty buffer completes immediately without touching pixels.
               state_next = (size_clamped == '0) ? DONE : RECV;
            end
         end
         RECV: begin
            if (!recv_px_empty) begin
               px_pop = 1'b1;
               if (last_px) begin
                  idx_next   = '0;
                  state_next = DONE;
               end else begin
                  idx_next = idx + ONE;
               end
            end
         end
         DONE: begin
            // Control FIFOs are deliberately not looked at here, so the next
            // set is popped no earlier than the first IDLE cycle.
            if (result_ack) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Pops must not leak out while reset holds the state machine.
      if (rst) begin
         ctrl_pop = 1'b0;
         px_pop   = 1'b0;
      end
   end

   assign recv_buff_size_rd           = ctrl_pop;
   assign recv_pivot_rd               = ctrl_pop;
   assign recv_median_pos_rd          = ctrl_pop;
   assign recv_second_median_value_rd = ctrl_pop;
   assign recv_px_rd                  = px_pop;

   assign buf_wr   = px_pop;
   assign buf_addr = idx;
   assign buf_data = recv_px;

   assign result_valid = (state == DONE);
   assign receiving    = (state == RECV);

   // ------------------------------------------------------------------
   // Pivot statistics
   // ------------------------------------------------------------------
`ifdef RECV_PIVOT_STATS_EN
   logic [BUFF_SIZE_BIT-1:0] lt_cnt;
   logic [BUFF_SIZE_BIT-1:0] eq_cnt;
   logic [BUFF_SIZE_BIT-1:0] gt_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lt_cnt <= '0;
         eq_cnt <= '0;
         gt_cnt <= '0;
      end else if (ctrl_pop) begin
         lt_cnt <= '0;
         eq_cnt <= '0;
         gt_cnt <= '0;
      end else if (px_pop) begin
         if (recv_px < pivot_q) begin
            lt_cnt <= lt_cnt + ONE;
         end else if (recv_px == pivot_q) begin
            eq_cnt <= eq_cnt + ONE;
         end else begin
            gt_cnt <= gt_cnt + ONE;
         end
      end
   end

   assign lt_count = lt_cnt;
   assign eq_count = eq_cnt;
   assign gt_count = gt_cnt;
`else
   assign lt_count = '0;
   assign eq_count = '0;
   assign gt_count = '0;
`endif

endmodule

// File: tb/tb_recv_logic.sv
// ---------------------------------------------------------------------------
// tb_recv_logic
//
// Self-checking bench for recv_logic. The five input FIFOs are modelled as
// queues presented first-word-fall-through. Expected buffer writes and
// expected results are pushed to scoreboard queues when stimulus is loaded
// and popped when the DUT produces a write or raises result_valid.
// A table of buffer vectors is run in a loop; reset-in-flight and the
// DONE->IDLE control-pop timing are covered by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_recv_logic;

   localparam int BS  = 32;
   localparam int BSB = $clog2(BS) + 1;
   localparam int PW  = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [PW-1:0]  recv_px;
   logic           recv_px_empty;
   logic           recv_px_rd;
   logic [PW-1:0]  recv_pivot;
   logic           recv_pivot_empty;
   logic           recv_pivot_rd;
   logic [BSB-1:0] recv_buff_size;
   logic           recv_buff_size_empty;
   logic           recv_buff_size_rd;
   logic [BSB-1:0] recv_median_pos;
   logic           recv_median_pos_empty;
   logic           recv_median_pos_rd;
   logic [PW-1:0]  recv_second_median_value;
   logic           recv_second_median_value_empty;
   logic           recv_second_median_value_rd;
   logic           buf_wr;
   logic [BSB-1:0] buf_addr;
   logic [PW-1:0]  buf_data;
   logic [BSB-1:0] lt_count;
   logic [BSB-1:0] eq_count;
   logic [BSB-1:0] gt_count;
   logic [PW-1:0]  pivot_q;
   logic [BSB-1:0] buff_size_q;
   logic [BSB-1:0] median_pos_q;
   logic [PW-1:0]  second_median_value_q;
   logic           result_valid;
   logic           result_ack;
   logic           receiving;

   always #5 clk = ~clk;

   recv_logic #(.BUFF_SIZE(BS), .BUFF_SIZE_BIT(BSB), .PX_WIDTH(PW)) dut (
      .clk                            (clk),
      .rst                            (rst),
      .recv_px                        (recv_px),
      .recv_px_empty                  (recv_px_empty),
      .recv_px_rd                     (recv_px_rd),
      .recv_pivot                     (recv_pivot),
      .recv_pivot_empty               (recv_pivot_empty),
      .recv_pivot_rd                  (recv_pivot_rd),
      .recv_buff_size                 (recv_buff_size),
      .recv_buff_size_empty           (recv_buff_size_empty),
      .recv_buff_size_rd              (recv_buff_size_rd),
      .recv_median_pos                (recv_median_pos),
      .recv_median_pos_empty          (recv_median_pos_empty),
      .recv_median_pos_rd             (recv_median_pos_rd),
      .recv_second_median_value       (recv_second_median_value),
      .recv_second_median_value_empty (recv_second_median_value_empty),
      .recv_second_median_value_rd    (recv_second_median_value_rd),
      .buf_wr                         (buf_wr),
      .buf_addr                       (buf_addr),
      .buf_data                       (buf_data),
      .lt_count                       (lt_count),
      .eq_count                       (eq_count),
      .gt_count                       (gt_count),
      .pivot_q                        (pivot_q),
      .buff_size_q                    (buff_size_q),
      .median_pos_q                   (median_pos_q),
      .second_median_value_q          (second_median_value_q),
      .result_valid                   (result_valid),
      .result_ack                     (result_ack),
      .receiving                      (receiving)
   );

   // ---------------- test vector table ----------------
   typedef struct {
      string    name;
      int       size;
      int       pivot;
      int       pos;
      int       sec;
      logic [63:0] px;        // byte i = pixel i when npx <= 8
      int       npx;          // npx > 8: pixel i = (i*7) mod 256
      int       stall_after;  // px FIFO goes empty after this many pops
      int       stall_len;
      int       lt;
      int       eq;
      int       gt;
      int       size_q;
      int       lat;          // cycles from control pop to result_valid
   } vec_t;

   typedef struct packed {
      logic [BSB-1:0] addr;
      logic [PW-1:0]  data;
   } wr_t;

   typedef struct {
      int lt;
      int eq;
      int gt;
      int size_q;
      int pivot;
      int pos;
      int sec;
   } res_t;

   vec_t tbl [7];

   // FIFO models and scoreboards
   logic [PW-1:0]  px_fq   [$];
   logic [PW-1:0]  piv_fq  [$];
   logic [BSB-1:0] size_fq [$];
   logic [BSB-1:0] pos_fq  [$];
   logic [PW-1:0]  sec_fq  [$];
   wr_t            exp_wr  [$];
   res_t           res_q   [$];

   int checks = 0;
   int errors = 0;
   int stall_left;
   int stall_after;
   int stall_len;
   int popped;

   // observations from the most recent cycle
   logic [3:0]     obs_ctrl_rd;
   logic           obs_px_rd;
   logic           obs_rv;
   logic           obs_recv;
   int             obs_lt;
   int             obs_eq;
   int             obs_gt;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int exp_cnt(input int v);
`ifdef RECV_PIVOT_STATS_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   function automatic logic [PW-1:0] px_of(input vec_t v, input int i);
      logic [63:0] p;
      p = v.px;
      if (v.npx <= 8) return p[i*8 +: 8];
      return PW'((i * 7) % 256);
   endfunction

   task automatic clear_fifos();
      px_fq.delete();
      piv_fq.delete();
      size_fq.delete();
      pos_fq.delete();
      sec_fq.delete();
      exp_wr.delete();
      res_q.delete();
      stall_left  = 0;
      stall_after = 0;
      stall_len   = 0;
      popped      = 0;
   endtask

   task automatic push_ctrl(input int size, input int pivot, input int pos, input int sec);
      size_fq.push_back(BSB'(size));
      piv_fq.push_back(PW'(pivot));
      pos_fq.push_back(BSB'(pos));
      sec_fq.push_back(PW'(sec));
   endtask

   task automatic drive();
      recv_px_empty = (px_fq.size() == 0) || (stall_left > 0);
      recv_px       = (px_fq.size() != 0) ? px_fq[0] : '0;
      recv_pivot_empty = (piv_fq.size() == 0);
      recv_pivot       = (piv_fq.size() != 0) ? piv_fq[0] : '0;
      recv_buff_size_empty = (size_fq.size() == 0);
      recv_buff_size       = (size_fq.size() != 0) ? size_fq[0] : '0;
      recv_median_pos_empty = (pos_fq.size() == 0);
      recv_median_pos       = (pos_fq.size() != 0) ? pos_fq[0] : '0;
      recv_second_median_value_empty = (sec_fq.size() == 0);
      recv_second_median_value       = (sec_fq.size() != 0) ? sec_fq[0] : '0;
   endtask

   // One clock cycle: drive FIFO outputs, sample DUT mid-cycle, then apply
   // the pops the DUT performed at the following edge.
   task automatic cycle();
      logic stall_act;
      wr_t  e;
      drive();
      stall_act = (stall_left > 0);
      #1;
      obs_ctrl_rd = {recv_buff_size_rd, recv_pivot_rd, recv_median_pos_rd,
                     recv_second_median_value_rd};
      obs_px_rd = recv_px_rd;
      obs_rv    = result_valid;
      obs_recv  = receiving;
      obs_lt    = int'(lt_count);
      obs_eq    = int'(eq_count);
      obs_gt    = int'(gt_count);
      chk("wr_follows_rd", int'(buf_wr), int'(recv_px_rd));
      chk("px_rd_when_empty", int'(recv_px_rd & recv_px_empty), 0);
      chk("px_rd_outside_recv", int'(recv_px_rd & ~receiving), 0);
      if (obs_ctrl_rd != 4'h0) chk("ctrl_rd_together", int'(obs_ctrl_rd), 15);
      if (buf_wr) begin
         if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wr: addr=%0d data=%0d with no write expected",
                     buf_addr, buf_data);
         end else begin
            e = exp_wr.pop_front();
            chk("buf_addr", int'(buf_addr), int'(e.addr));
            chk("buf_data", int'(buf_data), int'(e.data));
         end
      end
      @(posedge clk);
      #1;
      if (stall_act) stall_left--;
      if (obs_px_rd && px_fq.size() != 0) begin
         void'(px_fq.pop_front());
         popped++;
         if (popped == stall_after && stall_len > 0) stall_left = stall_len;
      end
      if (obs_ctrl_rd[3] && size_fq.size() != 0) void'(size_fq.pop_front());
      if (obs_ctrl_rd[2] && piv_fq.size()  != 0) void'(piv_fq.pop_front());
      if (obs_ctrl_rd[1] && pos_fq.size()  != 0) void'(pos_fq.pop_front());
      if (obs_ctrl_rd[0] && sec_fq.size()  != 0) void'(sec_fq.pop_front());
   endtask

   task automatic run_vec(input vec_t v);
      int   sz;
      int   n;
      int   c;
      int   pop_cyc;
      bit   done;
      wr_t  w;
      res_t r;
      clear_fifos();
      push_ctrl(v.size, v.pivot, v.pos, v.sec);
      sz = (v.size > BS) ? BS : v.size;
      n  = (v.npx < sz) ? v.npx : sz;
      for (int i = 0; i < v.npx; i++) px_fq.push_back(px_of(v, i));
      for (int i = 0; i < n; i++) begin
         w.addr = BSB'(i);
         w.data = px_of(v, i);
         exp_wr.push_back(w);
      end
      r.lt = exp_cnt(v.lt);
      r.eq = exp_cnt(v.eq);
      r.gt = exp_cnt(v.gt);
      r.size_q = v.size_q;
      r.pivot = v.pivot;
      r.pos = v.pos;
      r.sec = v.sec;
      res_q.push_back(r);
      stall_after = v.stall_after;
      stall_len   = v.stall_len;
      result_ack  = 1'b0;

      c = 0;
      pop_cyc = -1;
      done = 1'b0;
      while (!done && c < 200) begin
         cycle();
         c++;
         if (obs_ctrl_rd != 4'h0 && pop_cyc < 0) pop_cyc = c;
         if (obs_rv) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: result_valid not seen within 200 cycles", v.name);
         return;
      end
      chk({v.name, " latency"}, c - pop_cyc, v.lat);
      chk({v.name, " receiving_in_done"}, int'(obs_recv), 0);
      if (res_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s result: result_valid with no result expected", v.name);
      end else begin
         r = res_q.pop_front();
         chk({v.name, " lt"}, obs_lt, r.lt);
         chk({v.name, " eq"}, obs_eq, r.eq);
         chk({v.name, " gt"}, obs_gt, r.gt);
         chk({v.name, " buff_size_q"}, int'(buff_size_q), r.size_q);
         chk({v.name, " pivot_q"}, int'(pivot_q), r.pivot);
         chk({v.name, " median_pos_q"}, int'(median_pos_q), r.pos);
         chk({v.name, " second_q"}, int'(second_median_value_q), r.sec);
`ifdef RECV_PIVOT_STATS_EN
         chk({v.name, " count_sum"}, obs_lt + obs_eq + obs_gt, int'(buff_size_q));
`endif
      end
      chk({v.name, " writes_left"}, exp_wr.size(), 0);
      chk({v.name, " px_left"}, px_fq.size(), v.npx - n);

      // Held in DONE without ack: outputs stay put.
      for (int k = 0; k < 2; k++) begin
         cycle();
         chk({v.name, " hold_valid"}, int'(obs_rv), 1);
         chk({v.name, " hold_lt"}, obs_lt, r.lt);
         chk({v.name, " hold_gt"}, obs_gt, r.gt);
      end
      result_ack = 1'b1;
      cycle();
      chk({v.name, " ack_cycle_valid"}, int'(obs_rv), 1);
      result_ack = 1'b0;
      cycle();
      chk({v.name, " after_ack_valid"}, int'(obs_rv), 0);
      chk({v.name, " after_ack_receiving"}, int'(obs_recv), 0);
      $display("vector %s: lat=%0d lt=%0d eq=%0d gt=%0d size_q=%0d",
               v.name, c - pop_cyc, obs_lt, obs_eq, obs_gt, r.size_q);
   endtask

   initial begin
      tbl[0] = '{"basic",   5, 10,  2,  0, {8'd0,8'd0,8'd0,8'd20,8'd10,8'd12,8'd10,8'd3},
                 5, 0, 0, 1, 2, 2, 5, 6};
      tbl[1] = '{"stall",   5, 10,  2,  0, {8'd0,8'd0,8'd0,8'd20,8'd10,8'd12,8'd10,8'd3},
                 5, 2, 3, 1, 2, 2, 5, 9};
      tbl[2] = '{"size0",   0, 33,  1,  9, 64'd0,
                 0, 0, 0, 0, 0, 0, 0, 1};
      tbl[3] = '{"clamp40", 40, 100, 20, 55, 64'd0,
                 40, 0, 0, 15, 0, 17, 32, 33};
      tbl[4] = '{"one_eq",  1,  0,  0,  1, {56'd0, 8'd0},
                 1, 0, 0, 0, 1, 0, 1, 2};
      tbl[5] = '{"extremes", 3, 255, 1, 200, {40'd0, 8'd254, 8'd0, 8'd255},
                 3, 0, 0, 2, 1, 0, 3, 4};
      tbl[6] = '{"full32",  32, 128, 16, 77, 64'd0,
                 32, 0, 0, 19, 0, 13, 32, 33};

      // ---------------- reset state ----------------
      rst = 1'b1;
      result_ack = 1'b0;
      clear_fifos();
      push_ctrl(4, 1, 2, 3);
      px_fq.push_back(8'd5);
      drive();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst ctrl_rd", int'({recv_buff_size_rd, recv_pivot_rd, recv_median_pos_rd,
                               recv_second_median_value_rd}), 0);
      chk("rst px_rd", int'(recv_px_rd), 0);
      chk("rst buf_wr", int'(buf_wr), 0);
      chk("rst result_valid", int'(result_valid), 0);
      chk("rst receiving", int'(receiving), 0);
      chk("rst counts", int'(lt_count) + int'(eq_count) + int'(gt_count), 0);
      chk("rst latched", int'(pivot_q) + int'(buff_size_q) + int'(median_pos_q) +
                         int'(second_median_value_q), 0);
      clear_fifos();
      drive();
      rst = 1'b0;

      // ---------------- table vectors ----------------
      foreach (tbl[i]) run_vec(tbl[i]);

      // ---------------- reset mid-RECV ----------------
      begin
         int c;
         clear_fifos();
         push_ctrl(5, 10, 2, 0);
         for (int i = 0; i < 5; i++) px_fq.push_back(PW'(i + 1));
         for (int i = 0; i < 5; i++) exp_wr.push_back(wr_t'{BSB'(i), PW'(i + 1)});
         c = 0;
         while (popped < 2 && c < 20) begin
            cycle();
            c++;
         end
         chk("midrst pops_before", popped, 2);
         rst = 1'b1;
         exp_wr.delete();
         drive();
         #1;
         chk("midrst px_rd", int'(recv_px_rd), 0);
         chk("midrst buf_wr", int'(buf_wr), 0);
         chk("midrst receiving", int'(receiving), 0);
         chk("midrst result_valid", int'(result_valid), 0);
         chk("midrst counts", int'(lt_count) + int'(eq_count) + int'(gt_count), 0);
         chk("midrst buff_size_q", int'(buff_size_q), 0);
         chk("midrst pivot_q", int'(pivot_q), 0);
         @(posedge clk);
         #2;
         rst = 1'b0;
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) begin
            cycle();
            chk("midrst idle_no_px_rd", int'(obs_px_rd), 0);
            chk("midrst idle_valid", int'(obs_rv), 0);
         end
         chk("midrst px_left", px_fq.size(), 3);
         $display("sequence reset_mid_recv: px_left=%0d", px_fq.size());
      end

      // ---------------- control pending during DONE, ack held 4 cycles ----------------
      begin
         int c;
         clear_fifos();
         push_ctrl(2, 5, 1, 6);
         push_ctrl(0, 7, 3, 4);
         px_fq.push_back(8'd1);
         px_fq.push_back(8'd9);
         exp_wr.push_back(wr_t'{BSB'(0), PW'(1)});
         exp_wr.push_back(wr_t'{BSB'(1), PW'(9)});
         c = 0;
         obs_rv = 1'b0;
         while (!obs_rv && c < 20) begin
            cycle();
            c++;
         end
         chk("ackhold reached_done", int'(obs_rv), 1);
         chk("ackhold done_no_ctrl_rd", int'(obs_ctrl_rd), 0);
         chk("ackhold first_lt", obs_lt, exp_cnt(1));
         chk("ackhold first_gt", obs_gt, exp_cnt(1));
         result_ack = 1'b1;
         cycle();
         chk("ackhold c1_valid", int'(obs_rv), 1);
         chk("ackhold c1_ctrl_rd", int'(obs_ctrl_rd), 0);
         cycle();
         chk("ackhold c2_valid", int'(obs_rv), 0);
         chk("ackhold c2_ctrl_rd", int'(obs_ctrl_rd), 15);
         cycle();
         chk("ackhold c3_valid", int'(obs_rv), 1);
         chk("ackhold c3_size_q", int'(buff_size_q), 0);
         chk("ackhold c3_pivot_q", int'(pivot_q), 7);
         chk("ackhold c3_counts", obs_lt + obs_eq + obs_gt, 0);
         cycle();
         chk("ackhold c4_valid", int'(obs_rv), 0);
         chk("ackhold c4_ctrl_rd", int'(obs_ctrl_rd), 0);
         result_ack = 1'b0;
         chk("ackhold ctrl_left", size_fq.size(), 0);
         $display("sequence ack_hold: ctrl_left=%0d", size_fq.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/recv_logic.md
RECV_LOGIC -- requirements
Module: recv_logic

Interface
REQ-001 SHALL have parameter BUFF_SIZE, default 32, max pixels per buffer.
REQ-002 SHALL have parameter BUFF_SIZE_BIT, default $clog2(BUFF_SIZE)+1, width of size/count/position fields.
REQ-003 SHALL have parameter PX_WIDTH, default 8, pixel and pivot width.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports recv_px / recv_px_empty / recv_px_rd  in/in/out  PX_WIDTH/1/1  pixel FIFO data, empty flag, pop.
REQ-007 SHALL have ports recv_pivot / recv_pivot_empty / recv_pivot_rd  in/in/out  PX_WIDTH/1/1  pivot FIFO.
REQ-008 SHALL have ports recv_buff_size / recv_buff_size_empty / recv_buff_size_rd  in/in/out  BUFF_SIZE_BIT/1/1  size FIFO.
REQ-009 SHALL have ports recv_median_pos / recv_median_pos_empty / recv_median_pos_rd  in/in/out  BUFF_SIZE_BIT/1/1  median position FIFO.
REQ-010 SHALL have ports recv_second_median_value / recv_second_median_value_empty / recv_second_median_value_rd  in/in/out  PX_WIDTH/1/1  second-median FIFO.
REQ-011 SHALL have ports buf_wr / buf_addr / buf_data  out  1/BUFF_SIZE_BIT/PX_WIDTH  local pixel buffer write port.
REQ-012 SHALL have ports lt_count / eq_count / gt_count  out  BUFF_SIZE_BIT each  pixels <, =, > pivot.
REQ-013 SHALL have ports pivot_q, buff_size_q, median_pos_q, second_median_value_q  out  widths as FIFOs  latched control.
REQ-014 SHALL have ports result_valid out 1, result_ack in 1, receiving out 1.

Function
REQ-015 All FIFOs SHALL be first-word-fall-through: data valid while empty=0, rd=1 pops that word at the clock edge.
REQ-016 FSM SHALL have states IDLE, RECV, DONE.
REQ-017 IDLE: when all four control FIFOs non-empty, SHALL assert all four control rd in the same cycle, latch data into *_q, clear counters, go to RECV; otherwise no rd.
REQ-018 Latched size SHALL be clamped: size > BUFF_SIZE stored as BUFF_SIZE.
REQ-019 Latched size 0 SHALL go IDLE -> DONE directly, no pixel pops, counts 0.
REQ-020 RECV: recv_px_rd = ~recv_px_empty; each pop SHALL same cycle assert buf_wr with buf_addr = pop index (0..size-1), buf_data = recv_px.
REQ-021 Each pop SHALL increment exactly one of lt/eq/gt_count by unsigned compare of recv_px vs pivot_q; counts valid next cycle.
REQ-022 Pop with index = size-1 SHALL be the last; next state DONE; index counter returns to 0.
REQ-023 recv_px_rd SHALL never be asserted outside RECV; empty FIFO stalls RECV without count change.
REQ-024 DONE: result_valid=1, outputs held stable; result_ack=1 SHALL return to IDLE next cycle; result_ack ignored in other states.
REQ-025 A new control set SHALL NOT be popped in the DONE->IDLE transition cycle; earliest pop is first IDLE cycle.
REQ-026 receiving SHALL equal (state==RECV).
REQ-027 Invariant at DONE: lt+eq+gt = latched size.

Reset
REQ-028 rst SHALL asynchronously force IDLE, index 0, all counts 0, all *_q 0, result_valid 0, receiving 0; all rd and buf_wr 0 combinationally during reset.
REQ-029 Reset mid-RECV SHALL abandon the buffer; no partial result; leftover pixels remain in FIFO.

Configuration
REQ-030 Macro RECV_PIVOT_STATS_EN SHALL, when defined, compile lt/eq/gt counters and compare per REQ-021.
REQ-031 Without RECV_PIVOT_STATS_EN, lt/eq/gt_count SHALL be constant 0; all other behaviour unchanged.

Verification
REQ-032 Control {size=5,pivot=10,pos=2,second=0}, pixels 3,10,12,10,20 no stalls -> buf_addr 0..4, DONE with lt=1,eq=2,gt=2, result_valid 6 cycles after control pop.
REQ-033 Same stream with px FIFO empty for 3 cycles after pixel 2 -> no rd during gap, identical final counts, DONE 3 cycles later.
REQ-034 size=0 -> no recv_px_rd, result_valid next cycle, counts 0; ack -> IDLE.
REQ-035 size=40 with BUFF_SIZE=32 -> buff_size_q=32, exactly 32 pops, addr wraps 31->0 counter.
REQ-036 rst asserted after 2 of 5 pixels -> immediate IDLE, outputs 0, remaining 3 pixels unpopped.
REQ-037 Control FIFOs non-empty while in DONE, ack held 4 cycles -> control popped only on first IDLE cycle; without RECV_PIVOT_STATS_EN counts read 0.
